// File: rtl/pcl_dose_pkg.sv
// Shared types and helpers for the two-solution dosing sequencer.
package pcl_dose_pkg;

   localparam int T_W_DEF = 16;
   localparam int N_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DOSE_A   = 3'd1,
      SETTLE_A = 3'd2,
      DOSE_B   = 3'd3,
      SETTLE_B = 3'd4,
      MIX      = 3'd5,
      FINISH   = 3'd6
   } phase_e;

   // Next phase of the current dose pair with nonzero duration, strictly after
   // cur (cur = IDLE means "from the top of the pair"). Returns IDLE when the
   // pair has no further nonzero phase.
   function automatic phase_e next_phase(input phase_e cur,
                                         input logic nz_a, input logic nz_sa,
                                         input logic nz_b, input logic nz_sb,
                                         input logic nz_m);
      logic [4:0] nz;
      int         first;
      logic       found;
      phase_e     p;
      nz    = {nz_m, nz_sb, nz_b, nz_sa, nz_a};
      first = (cur == IDLE) ? 0 : int'(cur);
      found = 1'b0;
      p     = IDLE;
      for (int i = 0; i < 5; i++) begin
         if (i >= first && nz[i] && !found) begin
            p     = phase_e'(3'(i + 1));
            found = 1'b1;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/pcl_dose_sequencer_timer.sv
// Loadable phase down-counter; counts only on tick and flags the last tick.
module pcl_phase_timer
   import pcl_dose_pkg::*;
#(
   parameter int T_W = T_W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic [T_W-1:0] load_val,
   input  logic           tick,
   output logic           expire
);

   logic [T_W-1:0] count;

   assign expire = tick && (count == T_W'(1));

   // Load on phase entry, otherwise count down once per tick until zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (tick && count != '0) begin
         count <= count - T_W'(1);
      end
   end

endmodule

// File: rtl/pcl_dose_sequencer.sv
// Sequences valve 1, valve 2 and the mixer dwell for a programmable number
// of dose pairs. All outputs are registered from the next-state decode.
module pcl_dose_sequencer
   import pcl_dose_pkg::*;
#(
   parameter int T_W = T_W_DEF,
   parameter int N_W = N_W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           tick,
   input  logic           start,
   input  logic           abort,
   input  logic [T_W-1:0] dose_a,
   input  logic [T_W-1:0] dose_b,
   input  logic [T_W-1:0] settle,
   input  logic [T_W-1:0] mix,
   input  logic [N_W-1:0] n_cycles,
   output logic           valve_a_open,
   output logic           valve_b_open,
   output logic           busy,
   output logic           done,
   output logic           aborted,
   output logic [N_W-1:0] cycle_idx
);

   phase_e         state, state_nxt, ph;
   logic [T_W-1:0] da_sh, db_sh, st_sh, mx_sh;
   logic [N_W-1:0] n_sh, idx_nxt;
   logic [T_W-1:0] cur_da, cur_db, cur_st, cur_mx, load_val;
   logic           nz_a, nz_s, nz_b, nz_m;
   logic           load, expire, abt_nxt;

   // In IDLE the config is being captured on this same edge, so decisions
   // use the live inputs; during a run they use the shadow copies.
   assign cur_da = (state == IDLE) ? dose_a : da_sh;
   assign cur_db = (state == IDLE) ? dose_b : db_sh;
   assign cur_st = (state == IDLE) ? settle : st_sh;
   assign cur_mx = (state == IDLE) ? mix    : mx_sh;
   assign nz_a   = (cur_da != '0);
   assign nz_s   = (cur_st != '0);
   assign nz_b   = (cur_db != '0);
   assign nz_m   = (cur_mx != '0);

   pcl_phase_timer #(.T_W(T_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .tick     (tick),
      .expire   (expire)
   );

   // Next-state, cycle index and timer load decisions.
   always_comb begin
      state_nxt = state;
      idx_nxt   = cycle_idx;
      load      = 1'b0;
      abt_nxt   = 1'b0;
      ph        = IDLE;
      load_val  = '0;
      if (state != IDLE && abort) begin
         state_nxt = IDLE;
         abt_nxt   = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx_nxt = '0;
                  if (n_cycles == '0) begin
                     // An empty run spends its single busy cycle in MIX
                     // (valves closed) so done lands two cycles after start.
                     state_nxt = MIX;
                  end else begin
                     ph = next_phase(IDLE, nz_a, nz_s, nz_b, nz_s, nz_m);
                     if (ph == IDLE) begin
                        state_nxt = FINISH;
                     end else begin
                        state_nxt = ph;
                        load      = 1'b1;
                     end
                  end
               end
            end
            FINISH: state_nxt = IDLE;
            default: begin
               if (state == MIX && n_sh == '0) begin
                  state_nxt = FINISH;
               end else if (expire) begin
                  ph = next_phase(state, nz_a, nz_s, nz_b, nz_s, nz_m);
                  if (ph != IDLE) begin
                     state_nxt = ph;
                     load      = 1'b1;
                  end else if (cycle_idx == n_sh - N_W'(1)) begin
                     state_nxt = FINISH;
                  end else begin
                     idx_nxt   = cycle_idx + N_W'(1);
                     state_nxt = next_phase(IDLE, nz_a, nz_s, nz_b, nz_s, nz_m);
                     load      = 1'b1;
                  end
               end
            end
         endcase
      end
      case (state_nxt)
         DOSE_A:            load_val = cur_da;
         SETTLE_A, SETTLE_B: load_val = cur_st;
         DOSE_B:            load_val = cur_db;
         MIX:               load_val = cur_mx;
         default:           load_val = '0;
      endcase
   end

   // State, registered outputs and config shadows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         valve_a_open <= 1'b0;
         valve_b_open <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
         cycle_idx    <= '0;
         da_sh        <= '0;
         db_sh        <= '0;
         st_sh        <= '0;
         mx_sh        <= '0;
         n_sh         <= '0;
      end else begin
         state        <= state_nxt;
         valve_a_open <= (state_nxt == DOSE_A);
         valve_b_open <= (state_nxt == DOSE_B);
         busy         <= (state_nxt != IDLE);
         done         <= (state_nxt == FINISH);
         aborted      <= abt_nxt;
         cycle_idx    <= idx_nxt;
         if (state == IDLE && start) begin
            da_sh <= dose_a;
            db_sh <= dose_b;
            st_sh <= settle;
            mx_sh <= mix;
            n_sh  <= n_cycles;
         end
      end
   end

endmodule

// File: tb/tb_pcl_dose_sequencer.sv
// Directed bench for pcl_dose_sequencer with a per-cycle expected-output queue.
module tb_pcl_dose_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, tick, start, abort;
   logic [15:0] dose_a, dose_b, settle, mix;
   logic [7:0]  n_cycles;
   logic        valve_a_open, valve_b_open, busy, done, aborted;
   logic [7:0]  cycle_idx;

   pcl_dose_sequencer #(.T_W(16), .N_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick         (tick),
      .start        (start),
      .abort        (abort),
      .dose_a       (dose_a),
      .dose_b       (dose_b),
      .settle       (settle),
      .mix          (mix),
      .n_cycles     (n_cycles),
      .valve_a_open (valve_a_open),
      .valve_b_open (valve_b_open),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .cycle_idx    (cycle_idx)
   );

   always #5 clk = ~clk;

   int cyc  = 0;
   int tper = 1;
   initial tick = 1'b1;
   // Cycle k runs from posedge k to posedge k+1; tick is high in cycles k%tper==0.
   always @(posedge clk) begin
      cyc++;
      #1 tick = ((cyc % tper) == 0);
   end

   int          vectors = 0, miscompares = 0;
   logic [12:0] expq[$];
   int          m_t, m_ab, m_lastidx;
   bit          m_stop;
   int          abort_cyc = -1, sbusy_cyc = -1;
   int          va_cnt = 0, done_cnt = 0;

   function automatic logic [12:0] obs();
      return {valve_a_open, valve_b_open, busy, done, aborted, cycle_idx};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic push_e(input bit va, input bit vb, input bit bs, input bit dn,
                         input bit ab, input int idx);
      expq.push_back({va, vb, bs, dn, ab, 8'(idx)});
   endtask

   // Emit one expected cycle; an abort sampled in cycle m_ab replaces the
   // cycle after it with an aborted pulse followed by idle.
   task automatic emit(input bit va, input bit vb, input bit bs, input bit dn,
                       input bit ab, input int idx);
      if (m_stop) return;
      if (m_ab >= 0 && m_t == m_ab + 1) begin
         push_e(0, 0, 0, 0, 1, m_lastidx);
         push_e(0, 0, 0, 0, 0, m_lastidx);
         m_stop = 1;
         return;
      end
      push_e(va, vb, bs, dn, ab, idx);
      m_lastidx = idx;
      m_t++;
   endtask

   task automatic build(input int s0, input int da, input int db, input int st,
                        input int mx, input int n, input int ab);
      int d[5];
      int rem;
      bit k;
      d = '{da, st, db, st, mx};
      m_t = s0 + 1; m_ab = ab; m_stop = 0; m_lastidx = 0;
      if (n == 0) emit(0, 0, 1, 0, 0, 0);
      for (int c = 0; c < n; c++) begin
         for (int p = 0; p < 5; p++) begin
            rem = d[p];
            while (rem > 0 && !m_stop) begin
               k = ((m_t % tper) == 0);
               emit(p == 0, p == 2, 1, 0, 0, c);
               if (k) rem--;
            end
         end
      end
      emit(0, 0, 1, 1, 0, m_lastidx);
      emit(0, 0, 0, 0, 0, m_lastidx);
   endtask

   // Called at a negedge: present config with start and queue the expected trace.
   task automatic launch(input int da, input int db, input int st, input int mx,
                         input int n, input int ab_rel);
      dose_a = 16'(da); dose_b = 16'(db); settle = 16'(st); mix = 16'(mx);
      n_cycles = 8'(n);
      start = 1'b1;
      abort_cyc = (ab_rel < 0) ? -1 : cyc + ab_rel;
      build(cyc, da, db, st, mx, n, abort_cyc);
   endtask

   task automatic drain();
      logic [12:0] e;
      while (expq.size() > 0) begin
         @(negedge clk);
         start    = (cyc == sbusy_cyc);
         abort    = (cyc == abort_cyc);
         dose_a   = 16'($urandom_range(1, 9));
         dose_b   = 16'($urandom_range(1, 9));
         settle   = 16'($urandom_range(1, 9));
         mix      = 16'($urandom_range(1, 9));
         n_cycles = 8'($urandom_range(1, 9));
         e = expq.pop_front();
         if (valve_a_open) va_cnt++;
         if (done) done_cnt++;
         chk($sformatf("trace@%0d", cyc), 32'(obs()), 32'(e));
      end
      start = 1'b0;
      abort = 1'b0;
      sbusy_cyc = -1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      dose_a = '0; dose_b = '0; settle = '0; mix = '0; n_cycles = '0;
      #3 chk("reset_state", 32'(obs()), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", 32'(obs()), 32'd0);

      // Single pair, tick every clock.
      launch(3, 4, 2, 5, 1, -1);
      drain();

      // Three pairs, tick every 4th clock, start aligned to a tick cycle.
      tper = 4;
      while ((cyc % 4) != 0) @(negedge clk);
      va_cnt = 0; done_cnt = 0;
      launch(3, 4, 2, 5, 3, -1);
      drain();
      chk("slow_tick_valve_a_clocks", 32'(va_cnt), 32'd36);
      chk("slow_tick_done_pulses", 32'(done_cnt), 32'd1);
      tper = 1;
      @(negedge clk);

      // Only valve 2, back-to-back pairs.
      launch(0, 2, 0, 0, 2, -1);
      drain();

      // Empty run and all-zero durations.
      launch(3, 4, 2, 5, 0, -1);
      drain();
      launch(0, 0, 0, 0, 5, -1);
      drain();

      // Abort in the third DOSE_B cycle, with a start attempt while busy.
      sbusy_cyc = cyc + 3;
      launch(3, 4, 2, 5, 2, 8);
      drain();
      abort = 1'b1;
      @(negedge clk);
      chk("abort_in_idle", 32'(obs()), 32'd0);
      abort = 1'b0;

      // Start together with abort in IDLE: start wins.
      abort = 1'b1;
      launch(1, 1, 0, 1, 1, -1);
      drain();

      // Reset asserted mid-DOSE_A.
      launch(3, 4, 2, 5, 1, -1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         start = 1'b0;
         chk("pre_reset_trace", 32'(obs()), 32'(expq.pop_front()));
      end
      expq.delete();
      #2 rst_n = 1'b0;
      #1 chk("async_reset_clears", 32'(obs()), 32'd0);
      @(negedge clk);
      chk("reset_held", 32'(obs()), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_released", 32'(obs()), 32'd0);
      launch(3, 4, 2, 5, 2, -1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pcl_dose_sequencer.md
Name: pcl_dose_sequencer

Overview:
- Digital controller that sequences the two pneumatic valves and the downstream diffusion mixer of the two-solution dosing cell.
- Drives the air-side solenoid enables feeding valve 1 (solution 1) and valve 2 (solution 2).
  - Only one valve is ever open at a time.
  - A settle gap separates the two openings.
  - A mix dwell follows each dose pair.
- Repeats the dose pair a programmable number of times.
- Sits between the host/config register bank and the off-chip solenoid drivers.

Parameters:
- T_W, 16, width of all phase-duration operands, in tick units.
- N_W, 8, width of the repeat count and the cycle index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  timebase enable from the prescaler; timers decrement only on cycles where tick=1.
- start  in  1  request a run; sampled only in IDLE.
- abort  in  1  stop immediately; honoured in any non-IDLE state.
- dose_a  in  T_W  valve-1 open duration.
- dose_b  in  T_W  valve-2 open duration.
- settle  in  T_W  all-closed gap after each dose.
- mix  in  T_W  all-closed mixer dwell after the settle that follows dose_b.
- n_cycles  in  N_W  number of dose pairs per run.
- valve_a_open  out  1  solenoid enable for valve 1 (registered).
- valve_b_open  out  1  solenoid enable for valve 2 (registered).
- busy  out  1  high from the cycle after accepted start until return to IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort completion.
- cycle_idx  out  N_W  index of the current dose pair, 0-based.

Behaviour:
- Reset: state IDLE. All outputs 0: valve_a_open=0, valve_b_open=0, busy=0, done=0, aborted=0, cycle_idx=0. Shadow registers and timer are cleared.
- All outputs are registered; there is no combinational path from any input to any output.
- States and their outputs:
  - IDLE: valves closed, busy=0.
  - DOSE_A: valve_a_open=1, valve_b_open=0.
  - SETTLE_A: both valves closed.
  - DOSE_B: valve_b_open=1, valve_a_open=0.
  - SETTLE_B: both valves closed.
  - MIX: both valves closed.
  - FINISH: single cycle; pulses done and returns to IDLE.
- Start:
  - When start=1 in IDLE, dose_a, dose_b, settle, mix and n_cycles are captured into shadow registers.
  - Inputs may change freely after capture.
  - The next cycle enters the first phase with nonzero duration, with busy=1 and cycle_idx=0.
- Phase timer:
  - Loaded with the phase duration D on phase entry.
  - On a cycle with tick=1: if the timer equals 1, leave the phase; otherwise decrement.
  - Each phase therefore spans exactly D tick pulses. With tick held at 1, that is D clock cycles.
- Zero duration: a phase whose duration is 0 is skipped entirely. Advance to the next nonzero phase in the same transition; no extra cycle is spent.
- Phase order per cycle: DOSE_A → SETTLE_A → DOSE_B → SETTLE_B → MIX.
- After MIX (or the last nonzero phase of the cycle):
  - If cycle_idx == n_cycles−1, go to FINISH.
  - Otherwise increment cycle_idx and go to DOSE_A (or the first nonzero phase).
- End of run:
  - FINISH → IDLE next cycle.
  - busy=0 in IDLE.
  - cycle_idx holds its last value until the next accepted start.
- n_cycles=0: start is accepted, no phase is entered, FINISH follows, and done pulses on the second cycle after start. Valves never open.
- All durations 0 with n_cycles>0: the sequencer moves directly to FINISH.
- Abort:
  - On abort=1 in any non-IDLE state, both valves close the next cycle.
  - The state returns to IDLE and aborted pulses for one cycle; done does not pulse.
  - abort in IDLE is ignored.
  - abort and start together in IDLE: start wins.
- start while busy is ignored.
- Mutual exclusion: valve_a_open & valve_b_open is never 1, including across transitions. The DOSE_A→DOSE_B path when settle=0 is allowed and is glitch-free because both outputs are registered from a single state.
- Reset mid-run: valves drop to 0 asynchronously on rst_n low. No done or aborted pulse is produced.
- Width rules:
  - Timer width is T_W; durations up to 2^T_W−1 are legal.
  - cycle_idx width is N_W; it never wraps because it is bounded by n_cycles−1.

Decomposition:
- Package pcl_dose_pkg holds:
  - phase_e enum: IDLE, DOSE_A, SETTLE_A, DOSE_B, SETTLE_B, MIX, FINISH.
  - Default T_W and N_W.
  - next_phase function, which skips zero-duration phases.
- Sub-module pcl_phase_timer: a loadable T_W down-counter with tick enable.
  - Inputs: load, load value, tick.
  - Output: expire, asserted when tick=1 and count=1.

Test Plan:
- dose_a=3, settle=2, dose_b=4, mix=5, n_cycles=1, tick=1 → valve_a high cycles 1–3, low 4–5, valve_b high 6–9, low 10–11, mix 12–16, done pulse at cycle 17, busy low at cycle 18.
- Same config, n_cycles=3, tick every 4th clock → valve_a high for 12 clocks per cycle, cycle_idx steps 0,1,2, single done pulse, no overlap of the two valves.
- dose_a=0, settle=0, dose_b=2, mix=0, n_cycles=2 → only valve_b opens, 2 cycles each, back-to-back with no idle cycle between pairs, done after 4 valve cycles.
- n_cycles=0 → no valve activity, done at start+2; all durations 0 with n_cycles=5 → done, valves never high.
- abort asserted 2 cycles into DOSE_B → valve_b low next cycle, aborted pulse, done never asserted, busy low; start while busy ignored; start+abort in IDLE starts the run.
- rst_n pulled low mid-DOSE_A → valve_a drops immediately, all outputs 0, and a subsequent start runs the full sequence correctly.
